burst_rr_arbiter: RTL and testbench



---
 rtl/burst_rr_arbiter_pkg.sv | 14 +
 rtl/burst_rr_arbiter_if.sv | 31 +++
 rtl/burst_rr_arbiter_pick.sv | 28 ++
 rtl/burst_rr_arbiter.sv | 102 ++++++++++
 tb/tb_burst_rr_arbiter.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and helpers for the burst-limited round-robin arbiter.
package burst_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_rr_arbiter_if.sv
// Source/sink bundle of the arbiter: FWFT source side plus registered word stream.
interface burst_rr_arbiter_if
    import burst_rr_arbiter_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    localparam int IW = idx_w(WIDTH);

    logic [WIDTH-1:0]            WRITE_REQ;
    logic [WIDTH-1:0]            HOLD_REQ;
    logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0]            READ_GRANT;
    logic                        READY_OUT;
    logic [CNT_WIDTH-1:0]        BURST_LEN;
    logic                        WRITE_OUT;
    logic [DATA_WIDTH-1:0]       DATA_OUT;
    logic                        GRANT_VALID;
    logic [IW-1:0]               GRANT_ID;

    modport master (
        output WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT, BURST_LEN,
        input  READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_VALID, GRANT_ID
    );

    modport slave (
        input  WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT, BURST_LEN,
        output READ_GRANT, WRITE_OUT, DATA_OUT, GRANT_VALID, GRANT_ID
    );
endinterface

// File: rtl/burst_rr_arbiter_pick.sv
// Rotate-priority encoder: first set request scanning last+1, last+2, ... mod WIDTH.
module rr_pick
    import burst_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    input  logic [IW-1:0]    i_last,
    output logic             o_found,
    output logic [IW-1:0]    o_index
);
    int w_j;

    // Scan farthest-first so the nearest candidate after last wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_j     = 0;
        for (int k = WIDTH; k >= 1; k--) begin
            w_j = (int'(i_last) + k) % WIDTH;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_index = IW'(w_j);
            end
        end
    end
endmodule

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with per-grant burst limit and HOLD_REQ atomic sequences,
// feeding one registered word stream.
module burst_rr_arbiter
    import burst_rr_arbiter_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    burst_rr_arbiter_if.slave bus
);
    localparam int IW = idx_w(WIDTH);

    state_t                r_state;
    logic [IW-1:0]         r_owner;
    logic [IW-1:0]         r_last;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_write_out;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic                  w_found;
    logic [IW-1:0]         w_index;
    logic                  w_own_wr;
    logic                  w_own_hold;
    logic                  w_limit;
    logic                  w_release;
    logic                  w_read;
    logic [DATA_WIDTH-1:0] w_word;
    logic [WIDTH-1:0]      w_grant;

    rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_pick (
        .i_req   (bus.WRITE_REQ),
        .i_last  (r_last),
        .o_found (w_found),
        .o_index (w_index)
    );

    always_comb begin
        w_own_wr   = 1'b0;
        w_own_hold = 1'b0;
        w_word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_wr   = bus.WRITE_REQ[i];
                w_own_hold = bus.HOLD_REQ[i];
                w_word     = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // HOLD_REQ both overrides the burst limit and keeps an empty owner granted.
    assign w_limit   = (bus.BURST_LEN != '0) && (r_cnt >= bus.BURST_LEN) && !w_own_hold;
    assign w_release = w_limit || (!w_own_wr && !w_own_hold);
    assign w_read    = (r_state == GRANT) && w_own_wr && bus.READY_OUT && !w_release && !RST;

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < WIDTH; i++)
            w_grant[i] = w_read && (r_owner == IW'(i));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_last      <= IW'(WIDTH - 1);
            r_cnt       <= '0;
            r_write_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_write_out <= w_read;
            if (w_read)
                r_data_out <= w_word;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_index;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_last  <= r_owner;
                        r_state <= IDLE;
                    end else if (w_read && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.READ_GRANT  = w_grant;
    assign bus.WRITE_OUT   = r_write_out;
    assign bus.DATA_OUT    = r_data_out;
    assign bus.GRANT_VALID = (r_state == GRANT);
    assign bus.GRANT_ID    = r_owner;
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed cycle-by-cycle bench for burst_rr_arbiter; sources are modelled as
// FWFT FIFOs whose word value encodes {source, pop index}.
module tb_burst_rr_arbiter;
    import burst_rr_arbiter_pkg::*;

    localparam int W  = 5;
    localparam int DW = 32;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   loaded [W];
    int   popped [W] = '{default: 0};

    burst_rr_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    burst_rr_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wd(input int s, input int p);
        return {4'hA, 4'(s), 8'h00, 16'(p)};
    endfunction

    always @(posedge clk)
        for (int i = 0; i < W; i++)
            if (bus.READ_GRANT[i]) popped[i] <= popped[i] + 1;

    always_comb begin
        bus.WRITE_REQ = '0;
        bus.DATA_IN   = '0;
        for (int i = 0; i < W; i++) begin
            bus.WRITE_REQ[i]          = (loaded[i] != popped[i]);
            bus.DATA_IN[i*DW +: DW]   = wd(i, popped[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Check one cycle's outputs, then advance to the next negedge.
    task automatic step(input string tag, input logic [4:0] erg, input logic ewo,
                        input logic [31:0] edo, input logic egv);
        #1;
        chk({tag, ".rg"}, 32'(bus.READ_GRANT), 32'(erg));
        chk({tag, ".wo"}, 32'(bus.WRITE_OUT), 32'(ewo));
        chk({tag, ".do"}, bus.DATA_OUT, edo);
        chk({tag, ".gv"}, 32'(bus.GRANT_VALID), 32'(egv));
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < W; i++) loaded[i] = 0;
        rst           = 1'b1;
        bus.HOLD_REQ  = '0;
        bus.READY_OUT = 1'b1;
        bus.BURST_LEN = '0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("rst.id", 32'(bus.GRANT_ID), 32'd0);
        step("rst", 5'b00000, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        // single source, 4 words, unlimited burst
        loaded[0] = 4;
        step("s0", 5'b00000, 1'b0, 32'h0,    1'b0);
        step("s1", 5'b00001, 1'b0, 32'h0,    1'b1);
        step("s2", 5'b00001, 1'b1, wd(0, 0), 1'b1);
        step("s3", 5'b00001, 1'b1, wd(0, 1), 1'b1);
        step("s4", 5'b00001, 1'b1, wd(0, 2), 1'b1);
        step("s5", 5'b00000, 1'b1, wd(0, 3), 1'b1);
        step("s6", 5'b00000, 1'b0, wd(0, 3), 1'b0);

        // fairness: sources 1 and 3 always busy, burst of 2
        loaded[1] = 1000;
        loaded[3] = 1000;
        bus.BURST_LEN = 8'd2;
        step("f0", 5'b00000, 1'b0, wd(0, 3), 1'b0);
        step("f1", 5'b00010, 1'b0, wd(0, 3), 1'b1);
        step("f2", 5'b00010, 1'b1, wd(1, 0), 1'b1);
        step("f3", 5'b00000, 1'b1, wd(1, 1), 1'b1);
        step("f4", 5'b00000, 1'b0, wd(1, 1), 1'b0);
        step("f5", 5'b01000, 1'b0, wd(1, 1), 1'b1);
        step("f6", 5'b01000, 1'b1, wd(3, 0), 1'b1);
        step("f7", 5'b00000, 1'b1, wd(3, 1), 1'b1);
        step("f8", 5'b00000, 1'b0, wd(3, 1), 1'b0);
        #1 chk("f9.id", 32'(bus.GRANT_ID), 32'd1);
        step("f9", 5'b00010, 1'b0, wd(3, 1), 1'b1);
        loaded[1] = 3;
        loaded[3] = 2;
        step("f10", 5'b00000, 1'b1, wd(1, 2), 1'b1);
        step("f11", 5'b00000, 1'b0, wd(1, 2), 1'b0);

        // back-pressure on source 4, READY_OUT 1,0,0,1
        loaded[4] = 4;
        bus.BURST_LEN = '0;
        step("b0", 5'b00000, 1'b0, wd(1, 2), 1'b0);
        step("b1", 5'b10000, 1'b0, wd(1, 2), 1'b1);
        bus.READY_OUT = 1'b0;
        step("b2", 5'b00000, 1'b1, wd(4, 0), 1'b1);
        step("b3", 5'b00000, 1'b0, wd(4, 0), 1'b1);
        bus.READY_OUT = 1'b1;
        step("b4", 5'b10000, 1'b0, wd(4, 0), 1'b1);
        step("b5", 5'b10000, 1'b1, wd(4, 1), 1'b1);
        step("b6", 5'b10000, 1'b1, wd(4, 2), 1'b1);
        step("b7", 5'b00000, 1'b1, wd(4, 3), 1'b1);
        step("b8", 5'b00000, 1'b0, wd(4, 3), 1'b0);

        // reset mid-burst on source 2, then wrap-around with requests on 0 and 4
        loaded[2] = 1000;
        step("r0", 5'b00000, 1'b0, wd(4, 3), 1'b0);
        step("r1", 5'b00100, 1'b0, wd(4, 3), 1'b1);
        step("r2", 5'b00100, 1'b1, wd(2, 0), 1'b1);
        rst = 1'b1;
        step("r3", 5'b00000, 1'b1, wd(2, 1), 1'b1);
        rst = 1'b0;
        loaded[2] = 2;
        loaded[0] = 5;
        loaded[4] = 5;
        #1 chk("r4.id", 32'(bus.GRANT_ID), 32'd0);
        step("r4", 5'b00000, 1'b0, 32'h0,    1'b0);
        step("r5", 5'b00001, 1'b0, 32'h0,    1'b1);
        step("r6", 5'b00000, 1'b1, wd(0, 4), 1'b1);
        step("r7", 5'b00000, 1'b0, wd(0, 4), 1'b0);
        step("r8", 5'b10000, 1'b0, wd(0, 4), 1'b1);
        step("r9", 5'b00000, 1'b1, wd(4, 4), 1'b1);
        step("r10", 5'b00000, 1'b0, wd(4, 4), 1'b0);

        // hold: HOLD_REQ alone never wins; held owner ignores limit and empty gaps
        bus.HOLD_REQ = 5'b00001;
        step("p0", 5'b00000, 1'b0, wd(4, 4), 1'b0);
        step("p1", 5'b00000, 1'b0, wd(4, 4), 1'b0);
        loaded[0] = 7;
        loaded[2] = 1000;
        bus.BURST_LEN = 8'd1;
        step("h0", 5'b00000, 1'b0, wd(4, 4), 1'b0);
        step("h1", 5'b00001, 1'b0, wd(4, 4), 1'b1);
        step("h2", 5'b00001, 1'b1, wd(0, 5), 1'b1);
        step("h3", 5'b00000, 1'b1, wd(0, 6), 1'b1);
        #1 chk("h4.id", 32'(bus.GRANT_ID), 32'd0);
        step("h4", 5'b00000, 1'b0, wd(0, 6), 1'b1);
        step("h5", 5'b00000, 1'b0, wd(0, 6), 1'b1);
        loaded[0] = 9;
        step("h6", 5'b00001, 1'b0, wd(0, 6), 1'b1);
        step("h7", 5'b00001, 1'b1, wd(0, 7), 1'b1);
        bus.HOLD_REQ = '0;
        step("h8", 5'b00000, 1'b1, wd(0, 8), 1'b1);
        step("h9", 5'b00000, 1'b0, wd(0, 8), 1'b0);
        step("h10", 5'b00100, 1'b0, wd(0, 8), 1'b1);
        step("h11", 5'b00000, 1'b1, wd(2, 2), 1'b1);
        step("h12", 5'b00000, 1'b0, wd(2, 2), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
